// File: rtl/iob_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : iob_pkg
//  Description : Shared constants for the registered bidirectional bus port:
//                state encoding, turnaround counter width and tristate
//                polarity.
//  Revision    : 1.0 - initial release
// ============================================================================
package iob_pkg;

    // Turnaround counter width; covers TURNAROUND values 0..15
    localparam int TURN_CNT_W = 4;

    // State encoding
    localparam int         STATE_W = 2;
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] DRIVE   = 2'd1;
    localparam logic [1:0] TURN    = 2'd2;

    // Tristate polarity as seen by OBUFT/IOBUF T pins
    localparam logic T_HIZ   = 1'b1;
    localparam logic T_DRIVE = 1'b0;

endpackage : iob_pkg
`default_nettype wire

// File: rtl/iob_capture_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : iob_capture_pipe
//  Description : Shift pipeline of depth STAGES carrying captured pad data
//                together with its valid tag; synchronous clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module iob_capture_pipe #(
    parameter int WIDTH  = 17,
    parameter int STAGES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage [STAGES];

    // Shift the sample and its tag one stage per cycle; clear flushes all stages
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_data;
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[STAGES-1];

endmodule : iob_capture_pipe
`default_nettype wire

// File: rtl/iob_bidir_bus.sv
`default_nettype none
// ============================================================================
//  Module      : iob_bidir_bus
//  Description : Registered WIDTH-bit bidirectional bus port. Registered
//                output data and per-bit tristate control, registered input
//                capture with a valid tag, and a turnaround state machine
//                inserting high-Z dead cycles after the bus is released.
//  Revision    : 1.0 - initial release
// ============================================================================
module iob_bidir_bus
    import iob_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int TURNAROUND = 1,
    parameter int IN_STAGES  = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             drv_req,
    input  logic [WIDTH-1:0] drv_data,
    output logic             drv_ready,
    output logic [WIDTH-1:0] pad_o,
    output logic [WIDTH-1:0] pad_t,
    input  logic [WIDTH-1:0] pad_i,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             busy
);

    // Parameter range guard: out-of-range settings stop elaboration
    if (WIDTH < 1 || TURNAROUND < 0 || TURNAROUND > 15 ||
        IN_STAGES < 1 || IN_STAGES > 4) begin : g_param_check
        $error("iob_bidir_bus: parameter out of range");
    end

    localparam logic                  C_HAS_TURN  = (TURNAROUND > 0);
    localparam logic [TURN_CNT_W-1:0] C_TURN_LOAD =
        (TURNAROUND > 0) ? TURN_CNT_W'(TURNAROUND - 1) : '0;

    logic [STATE_W-1:0]    r_state;
    logic [STATE_W-1:0]    w_state_nxt;
    logic [TURN_CNT_W-1:0] r_cnt;
    logic [TURN_CNT_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0]      r_pad_o;
    logic [WIDTH-1:0]      w_pad_o_nxt;
    // One T register per bit so each can be packed into its own IOB
    logic [WIDTH-1:0]      r_pad_t;
    logic [WIDTH-1:0]      w_pad_t_nxt;
    logic [WIDTH:0]        w_cap_in;
    logic [WIDTH:0]        w_cap_out;

    // State, counter and pad registers; reset releases the bus with no turnaround
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_pad_o <= '0;
            r_pad_t <= {WIDTH{T_HIZ}};
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pad_o <= w_pad_o_nxt;
            r_pad_t <= w_pad_t_nxt;
        end
    end

    // Next-state and next pad values; pad_o holds its last word after release
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pad_o_nxt = r_pad_o;
        w_pad_t_nxt = r_pad_t;
        case (r_state)
            IDLE: begin
                if (drv_req) begin
                    w_state_nxt = DRIVE;
                    w_pad_o_nxt = drv_data;
                    w_pad_t_nxt = {WIDTH{T_DRIVE}};
                end
            end
            DRIVE: begin
                if (drv_req) begin
                    w_pad_o_nxt = drv_data;
                end else begin
                    w_pad_t_nxt = {WIDTH{T_HIZ}};
                    if (C_HAS_TURN) begin
                        w_state_nxt = TURN;
                        w_cnt_nxt   = C_TURN_LOAD;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            TURN: begin
                if (r_cnt == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_pad_t_nxt = {WIDTH{T_HIZ}};
            end
        endcase
    end

    // Samples are tagged valid only when the bus was released and settled
    assign w_cap_in = {(r_state == IDLE), pad_i};

    iob_capture_pipe #(
        .WIDTH  (WIDTH + 1),
        .STAGES (IN_STAGES)
    ) u_capture_pipe (
        .clk    (clock),
        .rst    (reset),
        .i_data (w_cap_in),
        .o_data (w_cap_out)
    );

    assign drv_ready = !reset && (r_state != TURN);
    assign busy      = (r_state == TURN);
    assign pad_o     = r_pad_o;
    assign pad_t     = r_pad_t;
    assign rd_data   = w_cap_out[WIDTH-1:0];
    assign rd_valid  = w_cap_out[WIDTH];

endmodule : iob_bidir_bus
`default_nettype wire

// File: tb/tb_iob_bidir_bus.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iob_bidir_bus
//  Description : Directed self-checking bench for iob_bidir_bus. Instance a
//                uses TURNAROUND=1/IN_STAGES=2, instance b TURNAROUND=3.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iob_bidir_bus;

    logic        clock;
    logic        reset;

    logic        drv_req_a;
    logic [15:0] drv_data_a;
    logic        drv_ready_a;
    logic [15:0] pad_o_a;
    logic [15:0] pad_t_a;
    logic [15:0] pad_i_a;
    logic [15:0] rd_data_a;
    logic        rd_valid_a;
    logic        busy_a;

    logic        drv_req_b;
    logic [15:0] drv_data_b;
    logic        drv_ready_b;
    logic [15:0] pad_o_b;
    logic [15:0] pad_t_b;
    logic [15:0] pad_i_b;
    logic [15:0] rd_data_b;
    logic        rd_valid_b;
    logic        busy_b;

    int n_cmp;
    int n_err;

    iob_bidir_bus #(
        .WIDTH      (16),
        .TURNAROUND (1),
        .IN_STAGES  (2)
    ) u_dut_a (
        .clock     (clock),
        .reset     (reset),
        .drv_req   (drv_req_a),
        .drv_data  (drv_data_a),
        .drv_ready (drv_ready_a),
        .pad_o     (pad_o_a),
        .pad_t     (pad_t_a),
        .pad_i     (pad_i_a),
        .rd_data   (rd_data_a),
        .rd_valid  (rd_valid_a),
        .busy      (busy_a)
    );

    iob_bidir_bus #(
        .WIDTH      (16),
        .TURNAROUND (3),
        .IN_STAGES  (1)
    ) u_dut_b (
        .clock     (clock),
        .reset     (reset),
        .drv_req   (drv_req_b),
        .drv_data  (drv_data_b),
        .drv_ready (drv_ready_b),
        .pad_o     (pad_o_b),
        .pad_t     (pad_t_b),
        .pad_i     (pad_i_b),
        .rd_data   (rd_data_b),
        .rd_valid  (rd_valid_b),
        .busy      (busy_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Compare one observed value against its expected value
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are stable 1 ns after the edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Safety net so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        reset      = 1'b1;
        drv_req_a  = 1'b0;
        drv_data_a = '0;
        pad_i_a    = '0;
        drv_req_b  = 1'b0;
        drv_data_b = '0;
        pad_i_b    = '0;

        // ---- reset held three cycles ----
        repeat (3) tick();
        check("rst_pad_t",     pad_t_a,     32'hFFFF);
        check("rst_pad_o",     pad_o_a,     32'h0000);
        check("rst_rd_valid",  rd_valid_a,  32'h0);
        check("rst_ready_low", drv_ready_a, 32'h0);
        reset = 1'b0;
        #1;
        check("idle_ready",    drv_ready_a, 32'h1);
        check("idle_busy",     busy_a,      32'h0);

        // ---- single write, TURNAROUND=1 ----
        drv_req_a  = 1'b1;
        drv_data_a = 16'hA5A5;
        tick();
        drv_req_a  = 1'b0;
        check("wr_pad_t",      pad_t_a,     32'h0000);
        check("wr_pad_o",      pad_o_a,     32'hA5A5);
        tick();
        check("rel_pad_t",     pad_t_a,     32'hFFFF);
        check("rel_busy",      busy_a,      32'h1);
        check("rel_ready",     drv_ready_a, 32'h0);
        check("rel_pad_o",     pad_o_a,     32'hA5A5);
        tick();
        check("turn_done_busy",  busy_a,      32'h0);
        check("turn_done_ready", drv_ready_a, 32'h1);

        // ---- burst of three words ----
        drv_req_a = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drv_data_a = 16'(i);
            tick();
            check("burst_pad_o", pad_o_a, 32'(i));
            check("burst_pad_t", pad_t_a, 32'h0000);
        end
        drv_req_a = 1'b0;
        tick();
        check("burst_rel_busy",  busy_a,      32'h1);
        check("burst_rel_pad_t", pad_t_a,     32'hFFFF);
        tick();
        check("burst_end_busy",  busy_a,      32'h0);
        check("burst_end_ready", drv_ready_a, 32'h1);

        // ---- read capture, IN_STAGES=2 ----
        pad_i_a = 16'hBEEF;
        tick();
        tick();
        check("rd_data_beef",  rd_data_a,  32'hBEEF);
        check("rd_valid_beef", rd_valid_a, 32'h1);
        // samples during DRIVE/TURN carry no valid tag
        pad_i_a    = 16'h1111;
        drv_req_a  = 1'b1;
        drv_data_a = 16'h0055;
        tick();
        drv_req_a = 1'b0;
        pad_i_a   = 16'h2222;
        tick();
        pad_i_a = 16'h3333;
        tick();
        check("rd_drive_data",  rd_data_a,  32'h2222);
        check("rd_drive_valid", rd_valid_a, 32'h0);
        pad_i_a = 16'h4444;
        tick();
        check("rd_turn_data",   rd_data_a,  32'h3333);
        check("rd_turn_valid",  rd_valid_a, 32'h0);
        tick();
        check("rd_idle_data",   rd_data_a,  32'h4444);
        check("rd_idle_valid",  rd_valid_a, 32'h1);

        // ---- reset mid-DRIVE ----
        drv_req_a  = 1'b1;
        drv_data_a = 16'h0F0F;
        tick();
        check("mid_pad_t_drive", pad_t_a, 32'h0000);
        reset = 1'b1;
        #1;
        check("mid_ready_rst",   drv_ready_a, 32'h0);
        tick();
        check("mid_pad_t",       pad_t_a,     32'hFFFF);
        check("mid_pad_o",       pad_o_a,     32'h0000);
        check("mid_busy",        busy_a,      32'h0);
        check("mid_rd_valid",    rd_valid_a,  32'h0);
        reset     = 1'b0;
        drv_req_a = 1'b0;
        pad_i_a   = 16'hCAFE;
        #1;
        check("mid_ready_after", drv_ready_a, 32'h1);
        tick();
        check("mid_busy_after",  busy_a,      32'h0);
        check("mid_valid_1",     rd_valid_a,  32'h0);
        tick();
        check("mid_valid_2",     rd_valid_a,  32'h1);
        check("mid_data_2",      rd_data_a,   32'hCAFE);

        // ---- held request across a release, TURNAROUND=3 ----
        drv_req_b  = 1'b1;
        drv_data_b = 16'hAAAA;
        tick();
        check("hold_first_pad_o", pad_o_b, 32'hAAAA);
        drv_req_b = 1'b0;
        tick();
        check("hold_rel_pad_t", pad_t_b, 32'hFFFF);
        drv_req_b  = 1'b1;
        drv_data_b = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_ready_low", drv_ready_b, 32'h0);
            check("hold_pad_t_hiz", pad_t_b,     32'hFFFF);
            tick();
        end
        check("hold_ready_4th", drv_ready_b, 32'h1);
        check("hold_busy_4th",  busy_b,      32'h0);
        tick();
        drv_req_b = 1'b0;
        check("hold_pad_o",     pad_o_b, 32'h1234);
        check("hold_pad_t",     pad_t_b, 32'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_iob_bidir_bus
`default_nettype wire
